// File: rtl/dpram_rd_streamer_pkg.sv
// Shared widths, latencies and the response record for the dual-port RAM read streamer.
// Optional feature macro: RD_TAG_EN adds the request address as a tag beside the read data.
package dpram_rd_streamer_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int MEM_DEPTH       = 16;
    localparam int ADDR_WIDTH      = $clog2(MEM_DEPTH);
    localparam int RD_LATENCYA     = 1;
    localparam int RD_LATENCYB     = 1;
    localparam int RESP_FIFO_DEPTH = 4;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef struct packed {
`ifdef RD_TAG_EN
        addr_t tag;
`endif
        data_t data;
    } rd_resp_t;

    // A one-entry FIFO still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dpram_rd_streamer_if.sv
// Request, RAM-port and response signals of the read streamer bundled as one interface.
// Optional feature macro: RD_TAG_EN adds o_rd_tag.
interface dpram_rd_streamer_if #(
    parameter int DATA_WIDTH = dpram_rd_streamer_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = dpram_rd_streamer_pkg::ADDR_WIDTH
);

    logic                  i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  o_req_ready;
    logic                  o_ram_en;
    logic                  o_ram_we;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [DATA_WIDTH-1:0] i_ram_dout;
    logic                  o_rd_valid;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  i_rd_ready;
`ifdef RD_TAG_EN
    logic [ADDR_WIDTH-1:0] o_rd_tag;
`endif

    // The streamer itself.
    modport slave (
        input  i_req_valid, i_req_addr, i_ram_dout, i_rd_ready,
        output o_req_ready, o_ram_en, o_ram_we, o_ram_addr, o_rd_valid, o_rd_data
`ifdef RD_TAG_EN
        , output o_rd_tag
`endif
    );

    // Requester, RAM port and consumer around the streamer.
    modport master (
        output i_req_valid, i_req_addr, i_ram_dout, i_rd_ready,
        input  o_req_ready, o_ram_en, o_ram_we, o_ram_addr, o_rd_valid, o_rd_data
`ifdef RD_TAG_EN
        , input o_rd_tag
`endif
    );

endinterface

// File: rtl/dpram_rd_streamer_rd_resp_fifo.sv
// Show-ahead synchronous FIFO holding read responses until the consumer takes them.
// Optional feature macro: RD_TAG_EN widens each entry by the tag field of rd_resp_t.
module rd_resp_fifo
    import dpram_rd_streamer_pkg::*;
#(
    parameter int DEPTH = RESP_FIFO_DEPTH
) (
    input  logic     i_clka,
    input  logic     i_rsta,
    input  logic     i_wr_en,
    input  rd_resp_t i_wr_data,
    input  logic     i_rd_en,
    output rd_resp_t o_rd_data,
    output logic     o_empty,
    output logic     o_full
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    rd_resp_t mem_q [DEPTH];
    ptr_t     wr_ptr_q, wr_ptr_d;
    ptr_t     rd_ptr_q, rd_ptr_d;
    cnt_t     count_q, count_d;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_wr_en) wr_ptr_d = next_ptr(wr_ptr_q);
        if (i_rd_en) rd_ptr_d = next_ptr(rd_ptr_q);
        unique case ({i_wr_en, i_rd_en})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clka) begin
        if (i_rsta) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; pointers and occupancy alone decide which entries are live.
    always_ff @(posedge i_clka) begin
        if (i_wr_en) mem_q[wr_ptr_q] <= i_wr_data;
    end

    assign o_rd_data = mem_q[rd_ptr_q];
    assign o_empty   = (count_q == '0);
    assign o_full    = (count_q == cnt_t'(DEPTH));

    a_no_overflow:  assert property (@(posedge i_clka) disable iff (i_rsta)
                                     !(i_wr_en && o_full && !i_rd_en));
    a_no_underflow: assert property (@(posedge i_clka) disable iff (i_rsta)
                                     !(i_rd_en && o_empty));

endmodule

// File: rtl/dpram_rd_streamer.sv
// Credit-based read front-end for one RAM port: issues reads, tracks them across the RAM latency
// and returns data as a backpressurable stream. Optional feature macro: RD_TAG_EN (adds o_rd_tag).
module dpram_rd_streamer #(
    parameter int DATA_WIDTH = dpram_rd_streamer_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = dpram_rd_streamer_pkg::ADDR_WIDTH,
    parameter int RD_LATENCY = dpram_rd_streamer_pkg::RD_LATENCYA,
    parameter int FIFO_DEPTH = dpram_rd_streamer_pkg::RESP_FIFO_DEPTH
) (
    input logic                i_clka,
    input logic                i_rsta,
    dpram_rd_streamer_if.slave bus
);

    import dpram_rd_streamer_pkg::*;

    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

    typedef logic [CRED_W-1:0] cred_t;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  req_ready;
    logic                  accept;
    logic                  pop;

    cred_t                 credits_q, credits_d;
    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [RD_LATENCY:0]   inflight_shift;

    rd_resp_t              fifo_wr_data;
    rd_resp_t              fifo_head;
    logic                  fifo_wr_en;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_valid;

    assign req_addr  = bus.i_req_addr;
    assign ram_dout  = bus.i_ram_dout;
    assign req_ready = (credits_q != '0) && !i_rsta;
    assign accept    = bus.i_req_valid && req_ready;
    assign fifo_valid = !fifo_empty;
    assign pop       = fifo_valid && bus.i_rd_ready;

    // One credit per FIFO slot: a read is issued only if its response is guaranteed a place.
    always_comb begin
        credits_d = credits_q;
        unique case ({accept, pop})
            2'b10:   credits_d = credits_q - cred_t'(1);
            2'b01:   credits_d = credits_q + cred_t'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        inflight_shift = {inflight_q, accept};
        inflight_d     = inflight_shift[RD_LATENCY-1:0];
    end

    assign fifo_wr_en = inflight_q[RD_LATENCY-1];

    always_ff @(posedge i_clka) begin
        if (i_rsta) begin
            credits_q  <= cred_t'(FIFO_DEPTH);
            inflight_q <= '0;
        end else begin
            credits_q  <= credits_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef RD_TAG_EN
    logic [ADDR_WIDTH-1:0] tag_pipe_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] tag_pipe_d [RD_LATENCY];

    // The address shifts beside the in-flight bit so it meets its data at the FIFO write.
    always_comb begin
        tag_pipe_d[0] = req_addr;
        for (int i = 1; i < RD_LATENCY; i++) tag_pipe_d[i] = tag_pipe_q[i-1];
    end

    always_ff @(posedge i_clka) begin
        if (i_rsta) begin
            for (int i = 0; i < RD_LATENCY; i++) tag_pipe_q[i] <= '0;
        end else begin
            for (int i = 0; i < RD_LATENCY; i++) tag_pipe_q[i] <= tag_pipe_d[i];
        end
    end
`endif

    always_comb begin
        fifo_wr_data      = '0;
        fifo_wr_data.data = ram_dout;
`ifdef RD_TAG_EN
        fifo_wr_data.tag  = tag_pipe_q[RD_LATENCY-1];
`endif
    end

    rd_resp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rd_resp_fifo (
        .i_clka    (i_clka),
        .i_rsta    (i_rsta),
        .i_wr_en   (fifo_wr_en),
        .i_wr_data (fifo_wr_data),
        .i_rd_en   (pop),
        .o_rd_data (fifo_head),
        .o_empty   (fifo_empty),
        .o_full    (fifo_full)
    );

    assign bus.o_req_ready = req_ready;
    assign bus.o_ram_en    = accept;
    assign bus.o_ram_we    = 1'b0;
    assign bus.o_ram_addr  = req_addr;
    assign bus.o_rd_valid  = fifo_valid;
    assign bus.o_rd_data   = fifo_head.data;
`ifdef RD_TAG_EN
    assign bus.o_rd_tag    = fifo_valid ? fifo_head.tag : '0;
`endif

    a_credit_bound: assert property (@(posedge i_clka) disable iff (i_rsta)
                                     credits_q <= cred_t'(FIFO_DEPTH));
    a_full_no_credit: assert property (@(posedge i_clka) disable iff (i_rsta)
                                       fifo_full |-> (credits_q == '0));

endmodule
